// File: rtl/lcd_serial_tx.sv
// ---------------------------------------------------------------------------
// lcd_serial_tx
//   Avalon-MM slave that serialises a CPU-written word onto the LCD panel's
//   lcd_sck / lcd_sda pins, framed by lcd_cs_n, at a programmable SCK rate.
//   Each SCK phase (setup, high, low) lasts H = divisor+1 clk cycles, so one
//   transfer keeps busy high for exactly H*(2*DATA_W+1) cycles.
//
//   Optional feature macro: LCD_SER_IRQ_EN
//     defined     -> irq port present, irq = done & CONTROL.irq_en
//     not defined -> no irq port, CONTROL b2 reads 0 and ignores writes
//
// Ports
//   clk, reset      system clock (rising edge), async active-high reset
//   address[1:0]    0=TXDATA 1=STATUS 2=DIVISOR 3=CONTROL
//   chipselect      slave select; write = chipselect & ~write_n
//   write_n/read_n  active-low strobes (reads are combinational, no wait)
//   writedata[31:0] write data
//   readdata[31:0]  read data, decoded from address only
//   lcd_sck         serial clock, idles low
//   lcd_sda         serial data, changes while lcd_sck is low
//   lcd_cs_n        active-low frame select
//   irq             done interrupt (LCD_SER_IRQ_EN builds only)
// ---------------------------------------------------------------------------
module lcd_serial_tx #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_sck,
  output logic        lcd_sda,
  output logic        lcd_cs_n
`ifdef LCD_SER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef LCD_SER_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   txdata_q, txdata_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                sck_q, sck_d;
  logic                sda_q, sda_d;
  logic                cs_n_q, cs_n_d;

  logic                wr;
  logic                wr_tx, wr_stat, wr_div, wr_ctl;
  logic                phase_end;
  logic [DATA_W-1:0]   shifted;

  // read_n carries no information for a zero-wait combinational read port
  logic                unused_bits;
  assign unused_bits = ^{read_n, writedata};

  assign wr      = chipselect & ~write_n;
  assign wr_tx   = wr && (address == 2'd0);
  assign wr_stat = wr && (address == 2'd1);
  assign wr_div  = wr && (address == 2'd2);
  assign wr_ctl  = wr && (address == 2'd3);

  // The counter runs 0..divisor and stops there, so it never exceeds the
  // divisor register and cannot wrap even when divisor is all ones.
  assign phase_end = (cnt_q == div_q);

  assign shifted = ctrl_q[0] ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d   = state_q;
    txdata_d  = txdata_q;
    shift_d   = shift_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    sck_d     = sck_q;
    sda_d     = sda_q;
    cs_n_d    = cs_n_q;

    if (wr_tx) begin
      txdata_d = writedata[DATA_W-1:0];
    end

    if (wr_div && (state_q == S_IDLE)) begin
      div_d = writedata[DIV_W-1:0];
    end

    if (wr_ctl && (state_q == S_IDLE)) begin
      ctrl_d = writedata[2:0] & CTRL_MASK;
      // dropping cs_hold releases a frame held open by a previous transfer
      if (!writedata[1]) begin
        cs_n_d = 1'b1;
      end
    end

    // Clears come first so that a set in the same cycle below wins.
    if (wr_stat) begin
      if (writedata[1]) done_d = 1'b0;
      if (writedata[2]) ovr_d  = 1'b0;
    end

    if (wr_tx && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_tx) begin
          state_d   = S_SETUP;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          shift_d   = writedata[DATA_W-1:0];
          sda_d     = ctrl_q[0] ? writedata[DATA_W-1] : writedata[0];
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      S_SETUP: begin
        if (phase_end) begin
          state_d = S_HIGH;
          sck_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_HIGH: begin
        if (phase_end) begin
          // falling edge: present the next bit for the following rising edge
          state_d = S_LOW;
          sck_d   = 1'b0;
          cnt_d   = '0;
          shift_d = shifted;
          sda_d   = ctrl_q[0] ? shifted[DATA_W-1] : shifted[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_LOW: begin
        if (phase_end) begin
          cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sda_d   = 1'b0;
            cs_n_d  = ~ctrl_q[1];
          end else begin
            state_d   = S_HIGH;
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      txdata_q  <= '0;
      shift_q   <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      ctrl_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      sck_q     <= 1'b0;
      sda_q     <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      txdata_q  <= txdata_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      sck_q     <= sck_d;
      sda_q     <= sda_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign lcd_sck  = sck_q;
  assign lcd_sda  = sda_q;
  assign lcd_cs_n = cs_n_q;

`ifdef LCD_SER_IRQ_EN
  assign irq = done_q & ctrl_q[2];
`endif

  always_comb begin
    case (address)
      2'd0:    readdata = 32'(txdata_q);
      2'd1:    readdata = {29'd0, ovr_q, done_q, busy_q};
      2'd2:    readdata = 32'(div_q);
      default: readdata = {29'd0, ctrl_q};
    endcase
  end

endmodule

// File: tb/tb_lcd_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_lcd_serial_tx
//   Directed + randomised bench for lcd_serial_tx. A transfer model derives
//   the expected busy length H*(2*DATA_W+1), the phase length H and the word
//   that a slave sampling on rising lcd_sck must reassemble.
//   Built with a 4-bit divisor so the all-ones divisor case stays short.
// ---------------------------------------------------------------------------
module tb_lcd_serial_tx;

  localparam int DATA_W      = 8;
  localparam int DIV_W       = 4;
  localparam int DEFAULT_DIV = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        lcd_sck;
  logic        lcd_sda;
  logic        lcd_cs_n;
`ifdef LCD_SER_IRQ_EN
  logic        irq;
`endif

  lcd_serial_tx #(
    .DATA_W      (DATA_W),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_sck    (lcd_sck),
    .lcd_sda    (lcd_sda),
    .lcd_cs_n   (lcd_cs_n)
`ifdef LCD_SER_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model of the programmed configuration
  int m_div;
  bit m_msb;
  bit m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called right after a falling edge; returns on the next falling edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
    if (a == 2'd2) m_div = int'(d) & ((1 << DIV_W) - 1);
    if (a == 2'd3) begin
      m_msb  = d[0];
      m_hold = d[1];
    end
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
    read_n     = 1'b1;
    address    = 2'd1;
  endtask

  function automatic int xfer_len();
    return (m_div + 1) * (2 * DATA_W + 1);
  endfunction

  // Start a transfer of word, watch it to completion and compare against the
  // model. Optionally inject one bus write at busy cycle inj_at (1-based).
  task automatic xfer(input logic [31:0] word, input int inj_at, input logic [1:0] inj_addr,
                      input logic [31:0] inj_data, input string tag);
    int h, len, cnt, run, bad_run, nbits, cs_bad, guard;
    logic prev_sck, busy;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] expw;
    h = m_div + 1;
    len = xfer_len();
    expw = word[DATA_W-1:0];
    cnt = 0; run = 0; bad_run = 0; nbits = 0; cs_bad = 0; guard = 0;
    prev_sck = 1'b0;
    cap = '0;
    address    = 2'd0;
    writedata  = word;
    chipselect = 1'b1;
    write_n    = 1'b0;
    while (guard < len + 50) begin
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd1;
      #1;
      busy = readdata[0];
      if (busy !== 1'b1) break;
      cnt++;
      if (lcd_cs_n !== 1'b0) cs_bad++;
      if (lcd_sck !== prev_sck) begin
        if (run != h) bad_run++;
        run = 0;
      end
      run++;
      if (lcd_sck === 1'b1 && prev_sck === 1'b0) begin
        if (m_msb) cap = {cap[DATA_W-2:0], lcd_sda};
        else if (nbits < DATA_W) cap[nbits] = lcd_sda;
        nbits++;
      end
      prev_sck = lcd_sck;
      if (cnt == inj_at) begin
        address    = inj_addr;
        writedata  = inj_data;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
      guard++;
    end
    if (run != h) bad_run++;
    check({tag, "_busy_len"}, cnt, len);
    check({tag, "_nbits"}, nbits, DATA_W);
    check({tag, "_word"}, 32'(cap), 32'(expw));
    check({tag, "_phase_runs_bad"}, bad_run, 0);
    check({tag, "_cs_low_bad"}, cs_bad, 0);
    check({tag, "_done"}, readdata[1], 1'b1);
    check({tag, "_end_sck"}, lcd_sck, 1'b0);
    check({tag, "_end_sda"}, lcd_sda, 1'b0);
    check({tag, "_end_cs_n"}, lcd_cs_n, m_hold ? 1'b0 : 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 2'd1;
    writedata  = '0;
    m_div      = DEFAULT_DIV;
    m_msb      = 1'b0;
    m_hold     = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_sck", lcd_sck, 1'b0);
    check("rst_sda", lcd_sda, 1'b0);
    check("rst_cs_n", lcd_cs_n, 1'b1);
    rd_check(2'd0, 32'd0, "rst_txdata");
    rd_check(2'd1, 32'd0, "rst_status");
    rd_check(2'd2, 32'(DEFAULT_DIV), "rst_div");
    rd_check(2'd3, 32'd0, "rst_ctrl");
`ifdef LCD_SER_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // DIV=0, MSB first, 0xA5
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd1);
    xfer(32'hA5, -1, 2'd0, 32'd0, "t2");
    check("t2_len_17", xfer_len(), 17);
    rd_check(2'd1, 32'd2, "t2_status");
    bus_write(2'd1, 32'h6);
    rd_check(2'd1, 32'd0, "t2_status_clr");

    // DIV=3, LSB first, 0x01
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd0);
    xfer(32'h01, -1, 2'd0, 32'd0, "t3");
    check("t3_len_68", xfer_len(), 68);
    bus_write(2'd1, 32'h6);

    // TXDATA overrun mid-transfer
    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'd1);
    w = $urandom;
    xfer(w, 5, 2'd0, 32'hFF, "t4");
    rd_check(2'd1, 32'h6, "t4_status_ovr");
    bus_write(2'd1, 32'h6);
    rd_check(2'd1, 32'd0, "t4_status_clr");

    // cs_hold across back-to-back words, DIVISOR write while busy ignored
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd3);
    xfer(32'h12, 9, 2'd2, 32'd7, "t5a");
    xfer(32'h34, -1, 2'd0, 32'd0, "t5b");
    rd_check(2'd2, 32'd2, "t5_div_kept");
    bus_write(2'd3, 32'd1);
    #1;
    check("t5_cs_release", lcd_cs_n, 1'b1);
    rd_check(2'd3, 32'd1, "t5_ctrl");
    bus_write(2'd1, 32'h6);

    // all-ones divisor: H = 2^DIV_W
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'd0);
    rd_check(2'd2, 32'((1 << DIV_W) - 1), "maxdiv_reg");
    xfer($urandom, -1, 2'd0, 32'd0, "maxdiv");
    bus_write(2'd1, 32'h6);

    // randomised transfers
    for (int i = 0; i < 6; i++) begin
      bus_write(2'd2, $urandom_range(0, 3));
      bus_write(2'd3, $urandom_range(0, 1));
      xfer($urandom, -1, 2'd0, 32'd0, $sformatf("rnd%0d", i));
      bus_write(2'd1, 32'h6);
    end

    // reset in the middle of bit 3
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd1);
    address    = 2'd0;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("t1_active_cs_n", lcd_cs_n, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("t1_sck", lcd_sck, 1'b0);
    check("t1_cs_n", lcd_cs_n, 1'b1);
    check("t1_sda", lcd_sda, 1'b0);
    rd_check(2'd1, 32'd0, "t1_status");
    rd_check(2'd2, 32'(DEFAULT_DIV), "t1_div");
    @(negedge clk);
    reset  = 1'b0;
    m_div  = DEFAULT_DIV;
    m_msb  = 1'b0;
    m_hold = 1'b0;
    @(negedge clk);
    xfer($urandom, -1, 2'd0, 32'd0, "post_rst");
    bus_write(2'd1, 32'h6);

`ifdef LCD_SER_IRQ_EN
    // irq level, and done set wins over a same-cycle STATUS clear
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd5);
    xfer($urandom, -1, 2'd0, 32'd0, "t6a");
    check("t6_irq_set", irq, 1'b1);
    bus_write(2'd1, 32'h2);
    #1;
    check("t6_irq_clr", irq, 1'b0);
    xfer($urandom, xfer_len(), 2'd1, 32'h2, "t6b");
    #1;
    check("t6_irq_kept", irq, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
